// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, CPOL/CPHA mode constants and
// small helpers used by both the master and slave sides.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CS_SETUP = 2'd1,
    XFER     = 2'd2,
    CS_HOLD  = 2'd3
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};
  localparam spi_mode_t SPI_MODE1 = '{cpol: 1'b0, cpha: 1'b1};
  localparam spi_mode_t SPI_MODE2 = '{cpol: 1'b1, cpha: 1'b0};
  localparam spi_mode_t SPI_MODE3 = '{cpol: 1'b1, cpha: 1'b1};

  // Number of SCLK edges in one word.
  function automatic int unsigned spi_edge_count(input int unsigned width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period timer and edge-strobe generator. tick_c fires every H sys
// clocks while run is high; while sclk_run is high each tick is an SCLK edge.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DIV_WIDTH  = 8
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst_n,
  input  logic                 run,
  input  logic                 sclk_run,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick_c,
  output logic                 lead_edge_c,
  output logic                 trail_edge_c,
  output logic                 last_edge_c
);

  localparam int unsigned EDGES  = spi_edge_count(DATA_WIDTH);
  localparam int unsigned EDGE_W = $clog2(EDGES + 1);

  logic [DIV_WIDTH-1:0] half_cnt_q;
  logic [EDGE_W-1:0]    edge_cnt_q;

  // Even edge count means the next edge is a leading (odd-numbered) one.
  assign tick_c       = run && (half_cnt_q == div);
  assign lead_edge_c  = tick_c && sclk_run && !edge_cnt_q[0];
  assign trail_edge_c = tick_c && sclk_run && edge_cnt_q[0];
  assign last_edge_c  = trail_edge_c && (edge_cnt_q == EDGE_W'(EDGES - 1));

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      half_cnt_q <= '0;
      edge_cnt_q <= '0;
    end else begin
      if (!run || tick_c) begin
        half_cnt_q <= '0;
      end else begin
        half_cnt_q <= half_cnt_q + DIV_WIDTH'(1);
      end
      if (!sclk_run) begin
        edge_cnt_q <= '0;
      end else if (tick_c) begin
        edge_cnt_q <= edge_cnt_q + EDGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_master_core.sv
// SPI master: one word per request, all four CPOL/CPHA modes, either bit order,
// programmable SCLK divider. Config is latched at accept.
module spi_master_core
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DIV_WIDTH  = 8
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic                  i_cpol,
  input  logic                  i_cpha,
  input  logic                  i_lsb_first,
  input  logic [DIV_WIDTH-1:0]  i_clk_div,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_busy,
  output logic                  o_spi_sclk,
  output logic                  o_spi_mosi,
  output logic                  o_spi_cs_n,
  input  logic                  i_spi_miso
);

  spi_state_e            state_q, state_nxt;
  spi_mode_t             mode_q, mode_nxt;
  logic                  lsb_q, lsb_nxt;
  logic [DIV_WIDTH-1:0]  div_q, div_nxt;
  logic [DATA_WIDTH-1:0] tx_sreg_q, tx_sreg_nxt;
  logic [DATA_WIDTH-1:0] rx_sreg_q, rx_sreg_nxt;
  logic [DATA_WIDTH-1:0] rx_data_nxt;
  logic                  rx_valid_nxt;
  logic                  sclk_nxt, mosi_nxt, cs_n_nxt;

  logic run_c, sclk_run_c;
  logic tick_c, lead_edge_c, trail_edge_c, last_edge_c;
  logic shift_c, sample_c;

  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] tx_shift(input logic [DATA_WIDTH-1:0] w,
                                                    input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rx_shift(input logic [DATA_WIDTH-1:0] w,
                                                    input logic lsb, input logic b);
    return lsb ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
  endfunction

  assign run_c      = (state_q != IDLE);
  assign sclk_run_c = (state_q == CS_SETUP) || (state_q == XFER);

  spi_clk_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .DIV_WIDTH  (DIV_WIDTH)
  ) u_clk_gen (
    .i_sys_clk    (i_sys_clk),
    .i_sys_rst_n  (i_sys_rst_n),
    .run          (run_c),
    .sclk_run     (sclk_run_c),
    .div          (div_q),
    .tick_c       (tick_c),
    .lead_edge_c  (lead_edge_c),
    .trail_edge_c (trail_edge_c),
    .last_edge_c  (last_edge_c)
  );

  // CPHA=0 drives its first bit at CS fall, so the final trailing edge must not shift.
  assign shift_c  = mode_q.cpha ? lead_edge_c : (trail_edge_c && !last_edge_c);
  assign sample_c = mode_q.cpha ? trail_edge_c : lead_edge_c;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state_q;
    mode_nxt     = mode_q;
    lsb_nxt      = lsb_q;
    div_nxt      = div_q;
    tx_sreg_nxt  = tx_sreg_q;
    rx_sreg_nxt  = rx_sreg_q;
    rx_data_nxt  = o_rx_data;
    rx_valid_nxt = 1'b0;
    sclk_nxt     = o_spi_sclk;
    mosi_nxt     = o_spi_mosi;
    cs_n_nxt     = o_spi_cs_n;

    case (state_q)
      IDLE: begin
        sclk_nxt = mode_q.cpol;
        mosi_nxt = 1'b0;
        if (i_tx_valid) begin
          state_nxt   = CS_SETUP;
          mode_nxt    = '{cpol: i_cpol, cpha: i_cpha};
          lsb_nxt     = i_lsb_first;
          div_nxt     = i_clk_div;
          rx_sreg_nxt = '0;
          cs_n_nxt    = 1'b0;
          sclk_nxt    = i_cpol;
          tx_sreg_nxt = i_tx_data;
          if (!i_cpha) begin
            mosi_nxt    = head_bit(i_tx_data, i_lsb_first);
            tx_sreg_nxt = tx_shift(i_tx_data, i_lsb_first);
          end
        end
      end
      CS_SETUP: begin
        if (tick_c) state_nxt = XFER;
      end
      XFER: begin
        if (last_edge_c) state_nxt = CS_HOLD;
      end
      CS_HOLD: begin
        if (tick_c) begin
          state_nxt    = IDLE;
          cs_n_nxt     = 1'b1;
          mosi_nxt     = 1'b0;
          rx_data_nxt  = rx_sreg_q;
          rx_valid_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (lead_edge_c || trail_edge_c) sclk_nxt = !o_spi_sclk;

    if (shift_c) begin
      mosi_nxt    = head_bit(tx_sreg_q, lsb_q);
      tx_sreg_nxt = tx_shift(tx_sreg_q, lsb_q);
    end

    if (sample_c) rx_sreg_nxt = rx_shift(rx_sreg_q, lsb_q, i_spi_miso);
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q    <= IDLE;
      mode_q     <= SPI_MODE0;
      lsb_q      <= 1'b0;
      div_q      <= '0;
      tx_sreg_q  <= '0;
      rx_sreg_q  <= '0;
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
      o_spi_sclk <= 1'b0;
      o_spi_mosi <= 1'b0;
      o_spi_cs_n <= 1'b1;
      o_tx_ready <= 1'b1;
      o_busy     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      mode_q     <= mode_nxt;
      lsb_q      <= lsb_nxt;
      div_q      <= div_nxt;
      tx_sreg_q  <= tx_sreg_nxt;
      rx_sreg_q  <= rx_sreg_nxt;
      o_rx_data  <= rx_data_nxt;
      o_rx_valid <= rx_valid_nxt;
      o_spi_sclk <= sclk_nxt;
      o_spi_mosi <= mosi_nxt;
      o_spi_cs_n <= cs_n_nxt;
      o_tx_ready <= (state_nxt == IDLE);
      o_busy     <= (state_nxt != IDLE);
    end
  end

endmodule

// File: doc/spi_master_core.md
SPI_MASTER_CORE -- requirements
Module: spi_master_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning bits per SPI word (range 4..32).
REQ-002 SHALL have parameter DIV_WIDTH, default 8, meaning width of the SCLK divider input.
REQ-003 SHALL have port i_sys_clk, input, 1, the single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 SHALL have port i_sys_rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-005 SHALL have port i_cpol, input, 1, SCLK idle level.
REQ-006 SHALL have port i_cpha, input, 1, where 0 = sample on leading edge and 1 = sample on trailing edge.
REQ-007 SHALL have port i_lsb_first, input, 1, bit order for both MOSI and MISO.
REQ-008 SHALL have port i_clk_div, input, DIV_WIDTH, giving SCLK half-period H = i_clk_div+1 sys clocks.
REQ-009 SHALL have port i_tx_data, input, DATA_WIDTH, the word to transmit.
REQ-010 SHALL have port i_tx_valid, input, 1, request to start a transfer.
REQ-011 SHALL have port o_tx_ready, output, 1, high only when the block can accept a request.
REQ-012 SHALL have port o_rx_data, output, DATA_WIDTH, the last received word.
REQ-013 SHALL have port o_rx_valid, output, 1, a one-cycle pulse when o_rx_data is updated.
REQ-014 SHALL have port o_busy, output, 1, high from accept until the transfer completes.
REQ-015 SHALL have ports o_spi_sclk, o_spi_mosi and o_spi_cs_n, all outputs of width 1 and all registered, plus input port i_spi_miso, 1.

Function
REQ-016 Accept: i_tx_valid && o_tx_ready at edge T latches i_tx_data, i_cpol, i_cpha, i_lsb_first and i_clk_div; changes to these inputs during a transfer SHALL have no effect.
REQ-017 States: IDLE -> CS_SETUP (on accept) -> XFER (after H cycles) -> CS_HOLD (after 2*DATA_WIDTH SCLK edges) -> IDLE (after H cycles).
REQ-018 o_tx_ready SHALL equal (state==IDLE); o_busy SHALL equal its inverse.
REQ-019 o_spi_cs_n SHALL go low at T+1 and high at T+1+(2*DATA_WIDTH+1)*H.
REQ-020 SCLK edges SHALL occur at T+1+k*H for k = 1..2*DATA_WIDTH; in IDLE, o_spi_sclk SHALL sit at the latched CPOL, and SHALL move to the new CPOL at T+1.
REQ-021 CPHA=0: the first MOSI bit SHALL be driven at T+1; MISO SHALL be sampled on leading edges and MOSI shifted on trailing edges, with no shift after the final trailing edge.
REQ-022 CPHA=1: MOSI SHALL be shifted on leading edges (first bit driven on edge 1) and MISO sampled on trailing edges.
REQ-023 The bit sent first SHALL be bit DATA_WIDTH-1 (MSB-first) or bit 0 (LSB-first), and the receive shift SHALL mirror the transmit order.
REQ-024 o_rx_valid SHALL pulse exactly one cycle, coincident with o_spi_cs_n rising; o_rx_data SHALL hold until the next completion.
REQ-025 Back-to-back: with i_tx_valid held high, o_spi_cs_n SHALL be high for exactly 1 cycle between words.
REQ-026 i_clk_div=0 (H=1) SHALL work: SCLK toggles every cycle during XFER.
REQ-027 i_tx_valid while busy SHALL be ignored and not queued.
REQ-028 o_spi_mosi SHALL hold its last value in CS_HOLD and be 0 in IDLE.

Reset
REQ-029 Reset SHALL asynchronously force state=IDLE, o_spi_cs_n=1, o_spi_sclk=0, o_spi_mosi=0, o_rx_valid=0, o_rx_data=0 and counters=0; the latched CPOL SHALL reset to 0.
REQ-030 Reset mid-transfer SHALL abort the transfer without an o_rx_valid pulse; o_tx_ready SHALL be 1 in the first cycle after release.

Structure
REQ-031 Package spi_pkg SHALL hold the state encoding (IDLE, CS_SETUP, XFER, CS_HOLD) and the SPI mode constants (CPOL/CPHA pairs); this package SHALL be shared with the slave side.
REQ-032 The half-period counter and edge-strobe generation SHALL be one sub-module, spi_clk_gen, emitting lead_edge and trail_edge strobes; the FSM and shift registers SHALL stay in the top module.

Verification
REQ-033 Mode 0, MSB-first, div=1, tx 0xA55A, MOSI looped to MISO -> o_rx_data=0xA55A, o_spi_cs_n low for 66 cycles, 32 SCLK edges.
REQ-034 Mode 3, LSB-first, div=0, tx 0x8001, slave model returns 0x1234 -> MOSI bit sequence starts 1,0,0..., o_rx_data=0x1234, SCLK idles high.
REQ-035 Mode 1 and mode 2, each with tx 0x00FF -> a slave model in the matching mode receives 0x00FF and its returned 0xFF00 is captured correctly.
REQ-036 i_tx_valid held high for 3 words (0x1111, 0x2222, 0x3333) -> 3 o_rx_valid pulses, cs_n high for exactly 1 cycle between words; i_cpol toggled mid-word has no effect.
REQ-037 Assert reset at SCLK edge 10 of a word -> o_spi_cs_n=1 immediately, no o_rx_valid pulse, and the next word completes normally.
